// File: rtl/odd_p_check_arb_if.sv
// Request/grant bundle between the nibble producers and the odd-parity check arbiter.
interface odd_p_check_arb_if #(
  parameter int CNT_W = 8
);
  logic [3:0]       req;
  logic [19:0]      data;
  logic             clr_err;
  logic [3:0]       gnt;
  logic [3:0]       ack;
  logic             ok;
  logic             busy;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output req, data, clr_err,
    input  gnt, ack, ok, busy, err_cnt
  );

  modport slave (
    input  req, data, clr_err,
    output gnt, ack, ok, busy, err_cnt
  );
endinterface

// File: rtl/odd_p_check_arb.sv
// Four-port round-robin arbiter sharing one 4-bit odd-parity checker (IDLE -> CHECK -> DONE).
// Define ODD_P_ARB_ERRCNT_EN to build the saturating error counter; otherwise err_cnt is tied to 0.
module odd_p_check_arb #(
  parameter int CNT_W = 8
) (
  input logic                clk,
  input logic                rst_n,
  odd_p_check_arb_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e     state_q, state_d;

  logic [1:0] ptr_q;
  logic [1:0] sel_q, sel_d;
  logic [3:0] gnt_q, gnt_d;
  logic [4:0] op_q;
  logic       res_q;

  logic [4:0] slot [4];
  logic [1:0] scan_idx [4];

  logic [3:0] ack_o;
  logic       ok_o;
  logic       busy_o;

  // Unpack the operand slots and the round-robin scan order starting at ptr.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_slot
      assign slot[gi]     = bus.data[5*gi +: 5];
      assign scan_idx[gi] = ptr_q + 2'(gi);
    end
  endgenerate

  // Scan downward so the lowest offset from ptr is the last (winning) write.
  always_comb begin
    sel_d = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      if (bus.req[scan_idx[k]]) begin
        sel_d = scan_idx[k];
      end
    end
    gnt_d = 4'b0001 << sel_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|bus.req) state_d = CHECK;
      CHECK:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ack_o  = 4'b0000;
    ok_o   = 1'b0;
    busy_o = (state_q != IDLE);
    if (state_q == DONE) begin
      ack_o = gnt_q;
      ok_o  = res_q;
    end
  end

  // Operand is frozen at the grant edge; later data/req changes cannot disturb it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 2'd0;
      sel_q <= 2'd0;
      gnt_q <= 4'b0000;
      op_q  <= 5'd0;
      res_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (|bus.req) begin
            sel_q <= sel_d;
            gnt_q <= gnt_d;
            op_q  <= slot[sel_d];
          end
        end
        CHECK: begin
          res_q <= ^op_q;
        end
        DONE: begin
          ptr_q <= sel_q + 2'd1;
          gnt_q <= 4'b0000;
        end
        default: begin
          gnt_q <= 4'b0000;
        end
      endcase
    end
  end

`ifdef ODD_P_ARB_ERRCNT_EN
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Clear beats a coincident increment; the count holds at all-ones.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (bus.clr_err) begin
      err_cnt_d = '0;
    end else if (state_q == DONE && !res_q && err_cnt_q != {CNT_W{1'b1}}) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.err_cnt = err_cnt_q;
`else
  logic unused_clr_err;
  assign unused_clr_err = bus.clr_err;
  assign bus.err_cnt    = '0;
`endif

  assign bus.gnt  = gnt_q;
  assign bus.ack  = ack_o;
  assign bus.ok   = ok_o;
  assign bus.busy = busy_o;

endmodule

// File: tb/tb_odd_p_check_arb.sv
// Directed-vector bench for odd_p_check_arb; error-count expectations follow ODD_P_ARB_ERRCNT_EN.
module tb_odd_p_check_arb;
  localparam int CNT_W = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  odd_p_check_arb_if #(.CNT_W(CNT_W)) bus ();

  odd_p_check_arb #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int err_m    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_slot(input int port, input logic p, input logic [3:0] i);
    bus.data[5*port +: 5] = {p, i};
  endtask

  // Caller has req[port] driven before the next edge and the FSM is IDLE.
  task automatic serve(input int port, input logic exp_ok, input logic clr);
    logic [3:0] oh;
    logic [4:0] saved;
    oh = 4'b0001 << port;
    @(posedge clk); #1;
    check("gnt", {28'd0, bus.gnt}, {28'd0, oh});
    check("busy", {31'd0, bus.busy}, 32'd1);
    check("ack_early", {28'd0, bus.ack}, 32'd0);
    saved = bus.data[5*port +: 5];
    bus.data[5*port +: 5] = ~saved;
    @(posedge clk); #1;
    check("ack", {28'd0, bus.ack}, {28'd0, oh});
    check("ok", {31'd0, bus.ok}, {31'd0, exp_ok});
    check("gnt_done", {28'd0, bus.gnt}, {28'd0, oh});
    bus.clr_err = clr;
`ifdef ODD_P_ARB_ERRCNT_EN
    if (clr) err_m = 0;
    else if (!exp_ok && err_m < (1 << CNT_W) - 1) err_m++;
`endif
    @(posedge clk); #1;
    bus.clr_err = 1'b0;
    bus.data[5*port +: 5] = saved;
    check("ack_width", {28'd0, bus.ack}, 32'd0);
    check("busy_idle", {31'd0, bus.busy}, 32'd0);
    check("gnt_clear", {28'd0, bus.gnt}, 32'd0);
    check("err_cnt", {30'd0, bus.err_cnt}, err_m);
    $display("txn port=%0d ok=%0b clr=%0b err_cnt=%0d", port, exp_ok, clr, bus.err_cnt);
  endtask

  logic [3:0] rot_port [5];
  logic       rot_ok   [4];

  initial begin
    bus.req = 4'b0000;
    bus.data = 20'd0;
    bus.clr_err = 1'b0;
    #2;
    check("rst_gnt", {28'd0, bus.gnt}, 32'd0);
    check("rst_ack", {28'd0, bus.ack}, 32'd0);
    check("rst_ok", {31'd0, bus.ok}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_err", {30'd0, bus.err_cnt}, 32'd0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single requester 0: {0,0010} has one set bit -> ok.
    set_slot(0, 1'b0, 4'b0010);
    bus.req[0] = 1'b1;
    serve(0, 1'b1, 1'b0);
    bus.req[0] = 1'b0;

    // Port 1 sequence: 3 ones ok, 4 ones fail, 4 ones fail.
    set_slot(1, 1'b1, 4'b0011); bus.req[1] = 1'b1;
    serve(1, 1'b1, 1'b0); bus.req[1] = 1'b0;
    set_slot(1, 1'b1, 4'b0111); bus.req[1] = 1'b1;
    serve(1, 1'b0, 1'b0); bus.req[1] = 1'b0;
    set_slot(1, 1'b0, 4'b1111); bus.req[1] = 1'b1;
    serve(1, 1'b0, 1'b0); bus.req[1] = 1'b0;

    // Three more zero-ones failures on port 3: count saturates at 3.
    set_slot(3, 1'b0, 4'b0000);
    for (int n = 0; n < 3; n++) begin
      bus.req[3] = 1'b1;
      serve(3, 1'b0, 1'b0);
      bus.req[3] = 1'b0;
    end

    // All four requesting continuously; ptr is 0 after port 3 finished.
    set_slot(0, 1'b0, 4'b0001);
    set_slot(1, 1'b0, 4'b0011);
    set_slot(2, 1'b1, 4'b0000);
    set_slot(3, 1'b1, 4'b1110);
    rot_ok[0] = 1'b1; rot_ok[1] = 1'b0; rot_ok[2] = 1'b1; rot_ok[3] = 1'b0;
    rot_port[0] = 4'd0; rot_port[1] = 4'd1; rot_port[2] = 4'd2;
    rot_port[3] = 4'd3; rot_port[4] = 4'd0;
    bus.req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      serve(int'(rot_port[n]), rot_ok[rot_port[n][1:0]], 1'b0);
    end
    bus.req = 4'b0000;

    // clr_err coincident with a failing ack on port 2: clear wins.
    set_slot(2, 1'b0, 4'b0011);
    bus.req[2] = 1'b1;
    serve(2, 1'b0, 1'b1);
    bus.req[2] = 1'b0;

    // Reset during CHECK of port 2 (ptr is 3 at this point).
    set_slot(2, 1'b1, 4'b0000);
    bus.req[2] = 1'b1;
    @(posedge clk); #1;
    check("pre_rst_gnt", {28'd0, bus.gnt}, 32'b0100);
    #2 rst_n = 1'b0;
    #1;
    check("arst_gnt", {28'd0, bus.gnt}, 32'd0);
    check("arst_busy", {31'd0, bus.busy}, 32'd0);
    check("arst_ack", {28'd0, bus.ack}, 32'd0);
    err_m = 0;
    @(posedge clk); #1;
    check("arst_no_ack", {28'd0, bus.ack}, 32'd0);
    check("arst_err", {30'd0, bus.err_cnt}, 32'd0);
    bus.req = 4'b0000;
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Ports 2 and 3 together: ptr restarted at 0 so port 2 wins first.
    set_slot(3, 1'b0, 4'b0111);
    bus.req = 4'b1100;
    serve(2, 1'b1, 1'b0);
    bus.req[2] = 1'b0;
    serve(3, 1'b1, 1'b0);
    bus.req = 4'b0000;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
